reg_lock_gate: RTL and testbench

//   Write-access gate directly upstream of a banked register array.
//   - Accepts write requests; maps each address to a lock region; issues the bank write strobe only if that region is unlocked.
//   - Lock bits are per region and sticky. One lock decides every entry of its region, so no entry in a bank can escape its region's lock.
//   - Returns a per-request response (ok / denied) and keeps a saturating count of denied writes.

---
 rtl/reg_lock_pkg.sv | 19 +
 rtl/reg_lock_bits.sv | 27 ++
 rtl/reg_lock_gate.sv | 142 ++++++++++++++
 tb/tb_reg_lock_gate.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_lock_pkg.sv
// Shared types and helpers for the register write-lock gate.
package reg_lock_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int DBG_KEY_W    = 8;
    localparam int REGION_IDX_W = 5;
    localparam int MAX_NREG     = 1 << REGION_IDX_W;

    // Wide one-hot region mask; callers cast it down to their own region count.
    function automatic logic [MAX_NREG-1:0] region_onehot(input logic [REGION_IDX_W-1:0] region);
        region_onehot         = '0;
        region_onehot[region] = 1'b1;
    endfunction

endpackage

// File: rtl/reg_lock_bits.sv
// Per-region sticky lock flops. The set mask outranks clear_all, so a region locked
// in the same cycle as a global clear ends up locked.
module reg_lock_bits #(
    parameter int NREG = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREG-1:0] set_mask,
    input  logic            clear_all,
    output logic [NREG-1:0] lock_state
);

    logic [NREG-1:0] lock_d;
    logic [NREG-1:0] lock_q;

    always_comb begin
        lock_d = (clear_all ? '0 : lock_q) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) lock_q <= '0;
        else     lock_q <= lock_d;
    end

    assign lock_state = lock_q;

endmodule

// File: rtl/reg_lock_gate.sv
// Write-access gate in front of a banked register array: region locks, ok/denied response,
// saturating deny counter. Optional debug unlock behind `LOCK_DEBUG_UNLOCK_EN.
module reg_lock_gate
    import reg_lock_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DW    = 2,
    parameter int RBITS = 1,
    parameter int CNTW  = 8
`ifdef LOCK_DEBUG_UNLOCK_EN
    ,
    parameter logic [DBG_KEY_W-1:0] DBG_KEY = 8'hA5
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AW-1:0]        req_addr,
    input  logic [DW-1:0]        req_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_err,
    input  logic                 lock_set_valid,
    input  logic [RBITS-1:0]     lock_set_region,
    output logic [(1<<RBITS)-1:0] lock_state,
    output logic                 bank_we,
    output logic [AW-1:0]        bank_addr,
    output logic [DW-1:0]        bank_wdata,
    output logic [CNTW-1:0]      deny_cnt
`ifdef LOCK_DEBUG_UNLOCK_EN
    ,
    input  logic                 dbg_unlock_valid,
    input  logic [DBG_KEY_W-1:0] dbg_key
`endif
);

    localparam int NREG = 1 << RBITS;

    state_t          state_q, state_d;
    logic            resp_err_q, resp_err_d;
    logic            bank_we_q, bank_we_d;
    logic [AW-1:0]   bank_addr_q, bank_addr_d;
    logic [DW-1:0]   bank_wdata_q, bank_wdata_d;
    logic [CNTW-1:0] deny_cnt_q, deny_cnt_d;

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] eff_lock;
    logic            accept;
    logic            clear_all;

    assign set_mask = lock_set_valid ? NREG'(region_onehot(REGION_IDX_W'(lock_set_region))) : '0;
    // A lock arriving with the request already applies to that request.
    assign eff_lock = lock_state | set_mask;
    assign accept   = req_valid && req_ready;

`ifdef LOCK_DEBUG_UNLOCK_EN
    logic lockout_q, lockout_d;
    logic unlock_try;

    assign unlock_try = dbg_unlock_valid && !lockout_q;
    assign clear_all  = unlock_try && (dbg_key == DBG_KEY);
    assign lockout_d  = lockout_q || (unlock_try && (dbg_key != DBG_KEY));

    always_ff @(posedge clk) begin
        if (rst) lockout_q <= 1'b0;
        else     lockout_q <= lockout_d;
    end
`else
    assign clear_all = 1'b0;
`endif

    reg_lock_bits #(.NREG(NREG)) u_lock_bits (
        .clk        (clk),
        .rst        (rst),
        .set_mask   (set_mask),
        .clear_all  (clear_all),
        .lock_state (lock_state)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        resp_err_d   = resp_err_q;
        bank_we_d    = 1'b0;
        bank_addr_d  = bank_addr_q;
        bank_wdata_d = bank_wdata_q;
        deny_cnt_d   = deny_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                    if (eff_lock[req_addr[AW-1 -: RBITS]]) begin
                        resp_err_d = 1'b1;
                        if (deny_cnt_q != '1) deny_cnt_d = deny_cnt_q + CNTW'(1);
                    end else begin
                        resp_err_d   = 1'b0;
                        bank_we_d    = 1'b1;
                        bank_addr_d  = req_addr;
                        bank_wdata_d = req_data;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d    = IDLE;
                    resp_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_err_q   <= 1'b0;
            bank_we_q    <= 1'b0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            deny_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            resp_err_q   <= resp_err_d;
            bank_we_q    <= bank_we_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
            deny_cnt_q   <= deny_cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_err_q;
    assign bank_we    = bank_we_q;
    assign bank_addr  = bank_addr_q;
    assign bank_wdata = bank_wdata_q;
    assign deny_cnt   = deny_cnt_q;

endmodule

// File: tb/tb_reg_lock_gate.sv
// Directed bench for reg_lock_gate: vector table plus stall, reset and (with
// LOCK_DEBUG_UNLOCK_EN) debug-unlock sequences. A CNTW=2 copy checks counter saturation.
module tb_reg_lock_gate;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_addr = '0;
    logic [1:0] req_data = '0;
    logic       resp_ready = 1'b0;
    logic       lock_set_valid = 1'b0;
    logic [0:0] lock_set_region = '0;
`ifdef LOCK_DEBUG_UNLOCK_EN
    logic       dbg_unlock_valid = 1'b0;
    logic [7:0] dbg_key = '0;
`endif

    logic       req_ready, resp_valid, resp_err, bank_we;
    logic [1:0] lock_state;
    logic [3:0] bank_addr;
    logic [1:0] bank_wdata;
    logic [7:0] deny_cnt;

    logic       req_ready_2, resp_valid_2, resp_err_2, bank_we_2;
    logic [1:0] lock_state_2;
    logic [3:0] bank_addr_2;
    logic [1:0] bank_wdata_2;
    logic [1:0] deny_cnt_2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_lock_gate dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
        .lock_set_valid(lock_set_valid), .lock_set_region(lock_set_region),
        .lock_state(lock_state),
        .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .deny_cnt(deny_cnt)
`ifdef LOCK_DEBUG_UNLOCK_EN
        , .dbg_unlock_valid(dbg_unlock_valid), .dbg_key(dbg_key)
`endif
    );

    reg_lock_gate #(.CNTW(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_2),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid_2), .resp_ready(resp_ready), .resp_err(resp_err_2),
        .lock_set_valid(lock_set_valid), .lock_set_region(lock_set_region),
        .lock_state(lock_state_2),
        .bank_we(bank_we_2), .bank_addr(bank_addr_2), .bank_wdata(bank_wdata_2),
        .deny_cnt(deny_cnt_2)
`ifdef LOCK_DEBUG_UNLOCK_EN
        , .dbg_unlock_valid(dbg_unlock_valid), .dbg_key(dbg_key)
`endif
    );

    typedef struct {
        logic       pre_v;
        logic [0:0] pre_r;
        logic       same_v;
        logic [0:0] same_r;
        logic [3:0] addr;
        logic [1:0] data;
        logic       exp_err;
        logic       exp_we;
        logic [1:0] exp_lock;
        logic [7:0] exp_deny;
        logic [1:0] exp_deny_sat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        if (v.pre_v) begin
            lock_set_valid  = 1'b1;
            lock_set_region = v.pre_r;
            step();
            lock_set_valid  = 1'b0;
        end
        req_valid       = 1'b1;
        req_addr        = v.addr;
        req_data        = v.data;
        lock_set_valid  = v.same_v;
        lock_set_region = v.same_r;
        check($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
        step();
        req_valid      = 1'b0;
        lock_set_valid = 1'b0;
        check($sformatf("v%0d_resp_valid", idx), 32'(resp_valid), 32'd1);
        check($sformatf("v%0d_resp_err", idx), 32'(resp_err), 32'(v.exp_err));
        check($sformatf("v%0d_bank_we", idx), 32'(bank_we), 32'(v.exp_we));
        if (v.exp_we) begin
            check($sformatf("v%0d_bank_addr", idx), 32'(bank_addr), 32'(v.addr));
            check($sformatf("v%0d_bank_wdata", idx), 32'(bank_wdata), 32'(v.data));
        end
        check($sformatf("v%0d_lock_state", idx), 32'(lock_state), 32'(v.exp_lock));
        check($sformatf("v%0d_deny_cnt", idx), 32'(deny_cnt), 32'(v.exp_deny));
        check($sformatf("v%0d_deny_cnt_sat", idx), 32'(deny_cnt_2), 32'(v.exp_deny_sat));
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check($sformatf("v%0d_done_resp_valid", idx), 32'(resp_valid), 32'd0);
        check($sformatf("v%0d_done_bank_we", idx), 32'(bank_we), 32'd0);
        check($sformatf("v%0d_done_req_ready", idx), 32'(req_ready), 32'd1);
    endtask

    initial begin
        //          pre_v pre_r same_v same_r addr   data   err  we   lock   deny  sat
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 2'b10, 1'b0, 1'b1, 2'b00, 8'd0, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hC, 2'b01, 1'b1, 1'b0, 2'b10, 8'd1, 2'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 2'b11, 1'b0, 1'b1, 2'b10, 8'd1, 2'd1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 2'b01, 1'b1, 1'b0, 2'b11, 8'd2, 2'd2};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 1'b0, 2'b11, 8'd3, 2'd3};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 2'b11, 1'b1, 1'b0, 2'b11, 8'd4, 2'd3};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 2'b10, 1'b1, 1'b0, 2'b11, 8'd5, 2'd3};

        do_reset();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_bank_we", 32'(bank_we), 32'd0);
        check("rst_bank_addr", 32'(bank_addr), 32'd0);
        check("rst_bank_wdata", 32'(bank_wdata), 32'd0);
        check("rst_lock_state", 32'(lock_state), 32'd0);
        check("rst_deny_cnt", 32'(deny_cnt), 32'd0);

        for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);

        // Stalled response: held stable, no new accept, mid-response lock ignored.
        do_reset();
        req_valid = 1'b1;
        req_addr  = 4'h6;
        req_data  = 2'b01;
        step();
        check("stall_first_we", 32'(bank_we), 32'd1);
        check("stall_first_addr", 32'(bank_addr), 32'h6);
        req_addr = 4'hE;
        req_data = 2'b10;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                lock_set_valid  = 1'b1;
                lock_set_region = 1'b0;
            end
            step();
            lock_set_valid = 1'b0;
            check($sformatf("stall%0d_resp_valid", i), 32'(resp_valid), 32'd1);
            check($sformatf("stall%0d_resp_err", i), 32'(resp_err), 32'd0);
            check($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("stall%0d_bank_we", i), 32'(bank_we), 32'd0);
        end
        check("stall_lock_state", 32'(lock_state), 32'b01);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("release_req_ready", 32'(req_ready), 32'd1);
        check("release_resp_valid", 32'(resp_valid), 32'd0);
        step();
        req_valid = 1'b0;
        check("next_bank_we", 32'(bank_we), 32'd1);
        check("next_bank_addr", 32'(bank_addr), 32'hE);
        check("next_bank_wdata", 32'(bank_wdata), 32'b10);
        check("next_resp_err", 32'(resp_err), 32'd0);

        // Reset while a response is pending drops it.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_lock_state", 32'(lock_state), 32'd0);
        check("midrst_bank_we", 32'(bank_we), 32'd0);

`ifdef LOCK_DEBUG_UNLOCK_EN
        do_reset();
        lock_set_valid = 1'b1;
        lock_set_region = 1'b0;
        step();
        lock_set_region = 1'b1;
        step();
        lock_set_valid = 1'b0;
        dbg_unlock_valid = 1'b1;
        dbg_key = 8'h3C;
        step();
        dbg_key = 8'hA5;
        step();
        dbg_unlock_valid = 1'b0;
        check("dbg_lockout_lock_state", 32'(lock_state), 32'b11);

        do_reset();
        lock_set_valid = 1'b1;
        lock_set_region = 1'b1;
        step();
        lock_set_valid = 1'b0;
        check("dbg_pre_lock_state", 32'(lock_state), 32'b10);
        dbg_unlock_valid = 1'b1;
        dbg_key = 8'hA5;
        step();
        dbg_unlock_valid = 1'b0;
        check("dbg_unlock_lock_state", 32'(lock_state), 32'b00);

        lock_set_valid = 1'b1;
        lock_set_region = 1'b0;
        step();
        lock_set_region = 1'b1;
        dbg_unlock_valid = 1'b1;
        step();
        lock_set_valid = 1'b0;
        dbg_unlock_valid = 1'b0;
        check("dbg_same_cycle_lock_state", 32'(lock_state), 32'b10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
